// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared ALU opcodes, muldiv FSM states and default data width
package cpu_pkg;

  localparam int MULDIV_W = 8;

  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ITER,
    ST_WB_LO,
    ST_WB_HI,
    ST_DONE
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_acc.sv
// rtl/muldiv_acc.sv - shift/add (MUL) and shift/subtract (DIV, macro MULDIV_SEQ_DIV_EN) accumulator
module muldiv_acc
  import cpu_pkg::*;
#(
  parameter int W = MULDIV_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         shr_add,
  input  logic [W-1:0] add_c,
  input  logic         add_carry,
`ifdef MULDIV_SEQ_DIV_EN
  input  logic         shl_sub,
  input  logic [W-1:0] sub_c,
  input  logic         sub_borrow,
  output logic [W-1:0] sh_rh,
`endif
  output logic [W-1:0] rh,
  output logic [W-1:0] rl
);

`ifdef MULDIV_SEQ_DIV_EN
  // HB is the top bit of the left-shifted {HB,RH,RL}. A set HB always forces
  // the subtract, which clears it again, so between steps HB is 0 and only
  // the shifted value needs to carry it.
  logic sh_hb;

  assign sh_hb = rh[W-1];
  assign sh_rh = {rh[W-2:0], rl[W-1]};

  // Load, then one shift-right-add (MUL) or shift-left-subtract (DIV) step per cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rh <= '0;
      rl <= '0;
    end else if (load) begin
      rh <= '0;
      rl <= load_val;
    end else if (shr_add) begin
      if (rl[0]) {rh, rl} <= {add_carry, add_c, rl[W-1:1]};
      else       {rh, rl} <= {rh, rl} >> 1;
    end else if (shl_sub) begin
      if (sh_hb || !sub_borrow) begin
        rh <= sub_c;
        rl <= {rl[W-2:0], 1'b1};
      end else begin
        rh <= sh_rh;
        rl <= {rl[W-2:0], 1'b0};
      end
    end
  end
`else
  // Load, then one shift-right-add step per cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rh <= '0;
      rl <= '0;
    end else if (load) begin
      rh <= '0;
      rl <= load_val;
    end else if (shr_add) begin
      if (rl[0]) {rh, rl} <= {add_carry, add_c, rl[W-1:1]};
      else       {rh, rl} <= {rh, rl} >> 1;
    end
  end
`endif

endmodule

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - sequential MUL/DIV over external regfile and ALU; DIV needs macro MULDIV_SEQ_DIV_EN
module muldiv_seq
  import cpu_pkg::*;
#(
  parameter int W = MULDIV_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         op,
  input  logic [7:0]   arg1,
  input  logic [7:0]   arg2,
  output logic         busy,
  output logic         done,
  output logic         div_zero,
  output logic         reg_r,
  output logic [7:0]   reg_r_select,
  input  logic [W-1:0] reg_r_line,
  output logic         reg_w,
  output logic [7:0]   reg_w_select,
  output logic [W-1:0] reg_w_line,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [3:0]   alu_op,
  input  logic [W-1:0] alu_c,
  input  logic         alu_carry
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  muldiv_state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [7:0]    a1_q, a2_q;
  logic          accept;
  logic          acc_load, acc_shr;
  logic [W-1:0]  rh, rl;

`ifdef MULDIV_SEQ_DIV_EN
  logic          op_q, dz_q, acc_shl;
  logic [W-1:0]  sh_rh;

  assign accept = start;
`else
  assign accept = start & ~op;
`endif

  muldiv_acc #(.W(W)) u_acc (
    .clk        (clk),
    .reset      (reset),
    .load       (acc_load),
    .load_val   (reg_r_line),
    .shr_add    (acc_shr),
    .add_c      (alu_c),
    .add_carry  (alu_carry),
`ifdef MULDIV_SEQ_DIV_EN
    .shl_sub    (acc_shl),
    .sub_c      (alu_c),
    .sub_borrow (alu_carry),
    .sh_rh      (sh_rh),
`endif
    .rh         (rh),
    .rl         (rl)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Operand capture at start, iteration counter, divide-by-zero flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      a1_q <= '0;
      a2_q <= '0;
`ifdef MULDIV_SEQ_DIV_EN
      op_q <= 1'b0;
      dz_q <= 1'b0;
`endif
    end else begin
      if (state == ST_IDLE && accept) begin
        a1_q <= arg1;
        a2_q <= arg2;
`ifdef MULDIV_SEQ_DIV_EN
        op_q <= op;
        dz_q <= 1'b0;
`endif
      end
      if (state == ST_ITER) begin
        cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
`ifdef MULDIV_SEQ_DIV_EN
        if (op_q && reg_r_line == '0) dz_q <= 1'b1;
`endif
      end
    end
  end

  // Next state and all port muxing
  always_comb begin
    state_nxt    = state;
    busy         = 1'b0;
    done         = 1'b0;
    div_zero     = 1'b0;
    reg_r        = 1'b0;
    reg_r_select = '0;
    reg_w        = 1'b0;
    reg_w_select = '0;
    reg_w_line   = '0;
    alu_a        = '0;
    alu_b        = '0;
    alu_op       = '0;
    acc_load     = 1'b0;
    acc_shr      = 1'b0;
`ifdef MULDIV_SEQ_DIV_EN
    acc_shl      = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (accept) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        busy         = 1'b1;
        reg_r        = 1'b1;
        reg_r_select = a2_q;
`ifdef MULDIV_SEQ_DIV_EN
        if (op_q) reg_r_select = a1_q;
`endif
        acc_load     = 1'b1;
        state_nxt    = ST_ITER;
      end
      ST_ITER: begin
        busy  = 1'b1;
        reg_r = 1'b1;
`ifdef MULDIV_SEQ_DIV_EN
        if (op_q) begin
          reg_r_select = a2_q;
          alu_a        = sh_rh;
          alu_b        = reg_r_line;
          alu_op       = OP_SUB;
          acc_shl      = 1'b1;
        end else
`endif
        begin
          reg_r_select = a1_q;
          alu_a        = reg_r_line;
          alu_b        = rh;
          alu_op       = OP_ADD;
          acc_shr      = 1'b1;
        end
        if (cnt == LAST) state_nxt = ST_WB_LO;
      end
      ST_WB_LO: begin
        busy         = 1'b1;
        reg_w        = 1'b1;
        reg_w_select = a1_q;
        reg_w_line   = rl;
        state_nxt    = ST_WB_HI;
      end
      ST_WB_HI: begin
        busy         = 1'b1;
        reg_w        = 1'b1;
        reg_w_select = a2_q;
        reg_w_line   = rh;
        state_nxt    = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
`ifdef MULDIV_SEQ_DIV_EN
        div_zero  = dz_q;
`endif
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - self-checking bench for muldiv_seq; DIV vectors follow macro MULDIV_SEQ_DIV_EN
module tb_muldiv_seq;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [7:0]  arg1 = '0, arg2 = '0;
  logic        busy, done, div_zero;
  logic        reg_r, reg_w;
  logic [7:0]  reg_r_select, reg_r_line, reg_w_select, reg_w_line;
  logic [7:0]  alu_a, alu_b, alu_c;
  logic [3:0]  alu_op;
  logic        alu_carry;

  logic [7:0]  regs[256];
  logic [7:0]  exp_regs[256];

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  bit          m_active = 1'b0;
  bit          m_op = 1'b0;
  int          m_t0 = 0;
  logic [7:0]  m_a1 = '0, m_a2 = '0, m_va1 = '0, m_va2 = '0;
  logic [16:0] m_res = '0;
  logic [7:0]  m_lo, m_hi;
  logic        m_dz, m_ok;

  assign m_lo = m_res[7:0];
  assign m_hi = m_res[15:8];
  assign m_dz = m_res[16];
`ifdef MULDIV_SEQ_DIV_EN
  assign m_ok = start;
`else
  assign m_ok = start & ~op;
`endif

  muldiv_seq dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .op           (op),
    .arg1         (arg1),
    .arg2         (arg2),
    .busy         (busy),
    .done         (done),
    .div_zero     (div_zero),
    .reg_r        (reg_r),
    .reg_r_select (reg_r_select),
    .reg_r_line   (reg_r_line),
    .reg_w        (reg_w),
    .reg_w_select (reg_w_select),
    .reg_w_line   (reg_w_line),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_c        (alu_c),
    .alu_carry    (alu_carry)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // external register file: combinational read, clocked write
  assign reg_r_line = regs[reg_r_select];
  always @(posedge clk) if (reg_w) regs[reg_w_select] <= reg_w_line;

  // external ALU: carry is the add carry-out or the subtract borrow
  always_comb begin
    alu_c = '0;
    alu_carry = 1'b0;
    case (alu_op)
      OP_ADD: {alu_carry, alu_c} = {1'b0, alu_a} + {1'b0, alu_b};
      OP_SUB: {alu_carry, alu_c} = {1'b0, alu_a} - {1'b0, alu_b};
      default: ;
    endcase
  end

  function automatic logic [16:0] op_result(input logic o, input logic [7:0] a, input logic [7:0] b);
    int p;
    if (!o) begin
      p = int'(a) * int'(b);
      return {1'b0, p[15:8], p[7:0]};
    end
    if (b == 0) return {1'b1, a, 8'hFF};
    return {1'b0, 8'(a % b), 8'(a / b)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // transaction-level model: accept, timeline anchor, expected register contents
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active <= 1'b0;
    end else if (!m_active) begin
      if (m_ok) begin
        m_active <= 1'b1;
        m_t0     <= cyc;
        m_op     <= op;
        m_a1     <= arg1;
        m_a2     <= arg2;
        m_va1    <= exp_regs[arg1];
        m_va2    <= exp_regs[arg2];
        m_res    <= op_result(op, exp_regs[arg1], exp_regs[arg2]);
      end
    end else begin
      if (cyc == m_t0 + 10) exp_regs[m_a1] <= m_lo;
      if (cyc == m_t0 + 11) exp_regs[m_a2] <= m_hi;
      if (cyc == m_t0 + 12) m_active <= 1'b0;
    end
  end

  // per-cycle comparison of every output against the model timeline
  always @(negedge clk) begin
    int rel;
    rel = cyc - m_t0;
    if (reset) begin
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_div_zero", div_zero, 0);
      chk("rst_reg_r", reg_r, 0);
      chk("rst_reg_w", reg_w, 0);
      chk("rst_alu_op", alu_op, 0);
    end else begin
      chk("busy", busy, m_active);
      chk("done", done, m_active && rel == 12);
      chk("div_zero", div_zero, m_active && rel == 12 && m_dz);
      chk("reg_r", reg_r, m_active && rel >= 1 && rel <= 9);
      chk("reg_w", reg_w, m_active && (rel == 10 || rel == 11));
      if (m_active && rel == 1) chk("load_sel", reg_r_select, m_op ? m_a1 : m_a2);
      if (m_active && rel >= 2 && rel <= 9) begin
        chk("iter_sel", reg_r_select, m_op ? m_a2 : m_a1);
        chk("iter_alu_op", alu_op, m_op ? OP_SUB : OP_ADD);
        if (m_op) chk("div_alu_b", alu_b, m_va2);
        else      chk("mul_alu_a", alu_a, m_va1);
      end else begin
        chk("idle_alu_a", alu_a, 0);
        chk("idle_alu_b", alu_b, 0);
        chk("idle_alu_op", alu_op, 0);
      end
      if (m_active && rel == 10) begin
        chk("wb_lo_sel", reg_w_select, m_a1);
        chk("wb_lo_data", reg_w_line, m_lo);
      end
      if (m_active && rel == 11) begin
        chk("wb_hi_sel", reg_w_select, m_a2);
        chk("wb_hi_data", reg_w_line, m_hi);
      end
    end
  end

  task automatic set_reg(input int idx, input logic [7:0] v);
    regs[idx] <= v;
    exp_regs[idx] <= v;
  endtask

  task automatic run_op(input logic o, input logic [7:0] a1, input logic [7:0] a2,
                        input int exp_lat, output bit dz_seen);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    dz_seen = 1'b0;
    @(negedge clk);
    start = 1'b1;
    op = o;
    arg1 = a1;
    arg2 = a2;
    while (n < 40 && !got) begin
      @(negedge clk);
      n++;
      if (n == 1) start = 1'b0;
      if (done) begin
        got = 1'b1;
        dz_seen = div_zero;
      end
    end
    if (exp_lat > 0) chk("done_latency", got ? n : 999, exp_lat);
    else             chk("op_ignored", got, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit dz;
    bit got;
    for (int i = 0; i < 256; i++) begin
      regs[i] <= 8'h00;
      exp_regs[i] <= 8'h00;
    end
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    reset = 1'b0;

    set_reg(1, 8'h0D); set_reg(2, 8'h0B);
    run_op(1'b0, 8'd1, 8'd2, 12, dz);
    chk("mul_0d_0b_lo", regs[1], 8'h8F);
    chk("mul_0d_0b_hi", regs[2], 8'h00);

    set_reg(1, 8'hFF); set_reg(2, 8'hFF);
    run_op(1'b0, 8'd1, 8'd2, 12, dz);
    chk("mul_ff_ff_lo", regs[1], 8'h01);
    chk("mul_ff_ff_hi", regs[2], 8'hFE);

`ifdef MULDIV_SEQ_DIV_EN
    set_reg(1, 8'd200); set_reg(2, 8'd7);
    run_op(1'b1, 8'd1, 8'd2, 12, dz);
    chk("div_200_7_q", regs[1], 8'h1C);
    chk("div_200_7_r", regs[2], 8'h04);
    chk("div_200_7_dz", dz, 0);

    set_reg(1, 8'hFF); set_reg(2, 8'h81);
    run_op(1'b1, 8'd1, 8'd2, 12, dz);
    chk("div_ff_81_q", regs[1], 8'h01);
    chk("div_ff_81_r", regs[2], 8'h7E);

    set_reg(1, 8'h5A); set_reg(2, 8'h00);
    run_op(1'b1, 8'd1, 8'd2, 12, dz);
    chk("div_zero_q", regs[1], 8'hFF);
    chk("div_zero_r", regs[2], 8'h5A);
    chk("div_zero_flag", dz, 1);
`else
    set_reg(1, 8'd200); set_reg(2, 8'd7);
    run_op(1'b1, 8'd1, 8'd2, 0, dz);
    chk("div_off_r1", regs[1], 8'hC8);
    chk("div_off_r2", regs[2], 8'h07);
`endif

    set_reg(3, 8'h10);
    run_op(1'b0, 8'd3, 8'd3, 12, dz);
    chk("same_reg_hi_wins", regs[3], 8'h01);

    set_reg(4, 8'h21); set_reg(5, 8'h03);
    @(negedge clk);
    start = 1'b1; op = 1'b0; arg1 = 8'd4; arg2 = 8'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("busy_before_reset", busy, 1);
    #1 reset = 1'b1;
    #1;
    chk("busy_in_reset", busy, 0);
    chk("reg_w_in_reset", reg_w, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("abandon_r4", regs[4], 8'h21);
    chk("abandon_r5", regs[5], 8'h03);

    run_op(1'b0, 8'd4, 8'd5, 12, dz);
    chk("after_reset_lo", regs[4], 8'h63);
    chk("after_reset_hi", regs[5], 8'h00);

    set_reg(6, 8'h12); set_reg(7, 8'h34); set_reg(8, 8'h0F); set_reg(9, 8'h0F);
    @(negedge clk);
    start = 1'b1; op = 1'b0; arg1 = 8'd6; arg2 = 8'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; arg1 = 8'd8; arg2 = 8'd9;
    @(negedge clk);
    start = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    chk("busy_start_done", got, 1);
    repeat (15) @(negedge clk);
    chk("busy_start_lo", regs[6], 8'hA8);
    chk("busy_start_hi", regs[7], 8'h03);
    chk("busy_start_r8", regs[8], 8'h0F);
    chk("busy_start_r9", regs[9], 8'h0F);

    for (int i = 0; i < 16; i++) chk("regfile", regs[i], exp_regs[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 Parameter: W, 8, data width in bits; the iteration count equals W.
REQ-002 Port: clk  in  1  single clock, rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-high reset.
REQ-004 Port: start  in  1  request pulse; sampled only in IDLE.
REQ-005 Port: op  in  1  0 = MUL, 1 = DIV; sampled with start.
REQ-006 Port: arg1 / arg2  in  8 each  register indices; sampled with start.
REQ-007 Port: busy / done  out  1 each  operation in flight / one-cycle completion pulse.
REQ-008 Port: div_zero  out  1  pulses with done when the DIV divisor was 0.
REQ-009 Ports: reg_r, reg_r_select[7:0], reg_r_line[7:0] (in, combinational same-cycle) form the register-file read port; reg_w, reg_w_select[7:0], reg_w_line[7:0] form the write port.
REQ-010 Ports: alu_a[7:0], alu_b[7:0], alu_op[3:0] (out); alu_c[7:0], alu_carry (in); the ALU is external and shared.

Function
REQ-011 The FSM SHALL have the states IDLE -> LOAD -> ITER (W cycles, counted by cnt) -> WB_LO -> WB_HI -> DONE -> IDLE.
REQ-012 busy SHALL be 1 in LOAD through DONE; done SHALL be 1 only in DONE; start seen in IDLE at cycle N SHALL give done at cycle N+W+4 (12 for W=8).
REQ-013 start while busy SHALL be ignored; start and done in the same cycle cannot occur because DONE precedes IDLE.
REQ-014 Accumulator {HB, RH[7:0], RL[7:0]} is 17 bits; MUL LOAD: read arg2, RL=line, RH=0, HB=0; DIV LOAD: read arg1, RL=dividend, RH=0, HB=0; the divisor is read from arg2 each ITER.
REQ-015 MUL ITER: read arg1; alu_a=line, alu_b=RH, alu_op=OP_ADD; if RL[0], {RH,RL} = {alu_carry, alu_c, RL[7:1]}; else {RH,RL} >>= 1.
REQ-016 DIV ITER (restoring): shift {HB,RH,RL} left 1; alu_a=shifted RH, alu_b=divisor, alu_op=OP_SUB; if HB or !alu_carry (no borrow), RH=alu_c, HB=0, RL[0]=1; else RL[0]=0.
REQ-017 WB_LO SHALL write RL to arg1 (MUL low product / DIV quotient); WB_HI SHALL write RH to arg2 (MUL high product / DIV remainder).
REQ-018 If arg1==arg2, the WB_HI value SHALL win.
REQ-019 Divisor 0 SHALL give quotient 0xFF and remainder = dividend, with div_zero=1 in DONE.
REQ-020 reg_r SHALL be 1 only in LOAD/ITER; reg_w only in WB_LO/WB_HI; outside ITER, alu_a, alu_b and alu_op SHALL be 0.

Reset
REQ-021 reset SHALL force IDLE immediately, including mid-operation; all outputs 0, accumulator and cnt 0; no register write SHALL occur; the operation is abandoned.

Configuration
REQ-022 With macro MULDIV_SEQ_DIV_EN defined, DIV is supported as specified.
REQ-023 Without MULDIV_SEQ_DIV_EN, start with op=1 SHALL be ignored (busy stays 0), div_zero SHALL be tied 0, and no DIV logic SHALL exist.

Structure
REQ-024 OP_ADD, OP_SUB, the FSM state enum and W default SHALL live in shared package cpu_pkg, used by the ALU and this block.
REQ-025 Sub-module muldiv_acc SHALL hold the 17-bit accumulator with load/shift-right-add/shift-left-sub controls; FSM and port muxing stay in muldiv_seq.

Verification
REQ-026 al=0x0D, bl=0x0B, MUL al,bl -> done at start+12; al=0x8F, bl=0x00.
REQ-027 al=bl=0xFF, MUL al,bl -> al=0x01, bl=0xFE, alu_carry path exercised.
REQ-028 al=200, bl=7, DIV -> al=0x1C, bl=0x04, div_zero=0.
REQ-029 al=0xFF, bl=0x81, DIV (HB path) -> al=0x01, bl=0x7E.
REQ-030 al=0x5A, bl=0, DIV -> al=0xFF, bl=0x5A, div_zero=1 with done.
REQ-031 Assert reset in the 4th ITER cycle -> busy=0 same cycle, no reg_w, registers unchanged; a later MUL completes correctly; start while busy is ignored.
